// File: rtl/set_time_editor.sv
// Set-mode date/time editor: debounced buttons with up/down auto-repeat, per-field
// BCD range arithmetic with leap-aware day clamping, and a commit/abort handshake.

module ste_button #(
  parameter int DEBOUNCE      = 16,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter bit REPEAT        = 1'b0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic hold_off,
  input  logic raw,
  output logic ev
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic          s1, s2, db, db_d, ph, blk, ev_r;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rc, lim_m1;

  assign lim_m1 = ph ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign ev     = ev_r & ~blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; db <= 1'b0; db_d <= 1'b0;
      ph <= 1'b0; blk <= 1'b0; ev_r <= 1'b0;
      dcnt <= '0; rc <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != db) begin
        if (dcnt == DW'(DEBOUNCE - 1)) begin
          db   <= s2;
          dcnt <= '0;
        end else dcnt <= dcnt + 1'b1;
      end else dcnt <= '0;
      db_d <= db;
      ev_r <= 1'b0;
      if (db && !db_d) begin
        ev_r <= 1'b1;
        rc   <= '0;
        ph   <= 1'b0;
      end else if (db && REPEAT) begin
        if (rc == lim_m1) begin
          ev_r <= 1'b1;
          rc   <= '0;
          ph   <= 1'b1;
        end else rc <= rc + 1'b1;
      end
      // A level already present outside EDIT stays masked until fully released.
      if (hold_off && (s2 || db)) blk <= 1'b1;
      else if (!s2 && !db)        blk <= 1'b0;
    end
  end
endmodule

module set_time_editor #(
  parameter int DEBOUNCE      = 16,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter bit SHOW_SEC      = 1'b1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        button_mid,
  input  logic        button_l,
  input  logic        button_r,
  input  logic        button_up,
  input  logic        button_down,
  input  logic [15:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_sec,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [3:0]  cursor,
  output logic        editing,
  output logic        commit
);
  localparam logic [3:0] CMAX = SHOW_SEC ? 4'd13 : 4'd11;
  localparam int MID = 0, BL = 1, BR = 2, UP = 3, DN = 4;

  typedef enum logic {IDLE, EDIT} state_t;
  state_t state, state_n;
  logic   en_d;
  logic [4:0] raw, ev;

  assign raw     = {button_down, button_up, button_r, button_l, button_mid};
  assign editing = (state == EDIT);

  for (genvar i = 0; i < 5; i++) begin : g_btn
    ste_button #(
      .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT(i >= UP)
    ) u_btn (
      .clk(clk), .rst_n(rst_n), .hold_off(state == IDLE), .raw(raw[i]), .ev(ev[i])
    );
  end

  function automatic logic [13:0] bcd2bin(input logic [15:0] b);
    return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100 + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
  endfunction

  function automatic logic [15:0] bin2bcd(input logic [13:0] v);
    return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10), 4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
  endfunction

  function automatic logic [13:0] dim(input logic [13:0] m, input logic [13:0] y);
    logic leap;
    leap = ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
    case (m)
      14'd2:                       return leap ? 14'd29 : 14'd28;
      14'd4, 14'd6, 14'd9, 14'd11: return 14'd30;
      default:                     return 14'd31;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      en_d  <= 1'b0;
    end else begin
      state <= state_n;
      en_d  <= enable;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable && !en_d) state_n = EDIT;
      default: if (!enable || ev[MID]) state_n = IDLE;
    endcase
  end

  // Field edit: fsel 0..5 = year, month, day, hour, minute, sec.
  logic [13:0] yb, mb, dbv, hb, nb, sb, v, mn, mx, st, nv, dmax;
  logic [13:0] ny, nm, nd, nh, nn, ns;
  logic [2:0]  fsel;
  logic        up;

  always_comb begin
    yb  = bcd2bin(year);
    mb  = bcd2bin({8'h00, month});
    dbv = bcd2bin({8'h00, day});
    hb  = bcd2bin({8'h00, hour});
    nb  = bcd2bin({8'h00, minute});
    sb  = bcd2bin({8'h00, sec});
    up  = ev[UP];
    fsel = (cursor < 4'd4) ? 3'd0 : cursor[3:1] - 3'd1;
    st   = cursor[0] ? 14'd1 : 14'd10;
    if (fsel == 3'd0) begin
      case (cursor[1:0])
        2'd0:    st = 14'd1000;
        2'd1:    st = 14'd100;
        2'd2:    st = 14'd10;
        default: st = 14'd1;
      endcase
    end
    v = yb; mn = 14'd0; mx = 14'd9999;
    case (fsel)
      3'd1:    begin v = mb;  mn = 14'd1; mx = 14'd12;      end
      3'd2:    begin v = dbv; mn = 14'd1; mx = dim(mb, yb); end
      3'd3:    begin v = hb;  mx = 14'd23;                  end
      3'd4:    begin v = nb;  mx = 14'd59;                  end
      3'd5:    begin v = sb;  mx = 14'd59;                  end
      default: ;
    endcase
    // Units wrap around the range; higher digits saturate.
    if (st == 14'd1) nv = up ? ((v == mx) ? mn : v + 14'd1) : ((v == mn) ? mx : v - 14'd1);
    else             nv = up ? ((v + st > mx) ? mx : v + st) : ((v < mn + st) ? mn : v - st);
    ny = yb; nm = mb; nd = dbv; nh = hb; nn = nb; ns = sb;
    case (fsel)
      3'd0:    ny = nv;
      3'd1:    nm = nv;
      3'd2:    nd = nv;
      3'd3:    nh = nv;
      3'd4:    nn = nv;
      default: ns = nv;
    endcase
    dmax = dim(nm, ny);
    if (nd > dmax) nd = dmax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year <= 16'h2000; month <= 8'h01; day <= 8'h01;
      hour <= 8'h00; minute <= 8'h00; sec <= 8'h00;
      cursor <= 4'd0;
      commit <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (state == IDLE) begin
        year <= cur_year; month <= cur_month; day <= cur_day;
        hour <= cur_hour; minute <= cur_minute; sec <= cur_sec;
        cursor <= 4'd0;
      end else if (!enable) begin
        cursor <= 4'd0;
      end else if (ev[MID]) begin
        commit <= 1'b1;
        cursor <= 4'd0;
        if (!SHOW_SEC) sec <= 8'h00;
      end else if (ev[UP] ^ ev[DN]) begin
        year   <= bin2bcd(ny);
        month  <= 8'(bin2bcd(nm));
        day    <= 8'(bin2bcd(nd));
        hour   <= 8'(bin2bcd(nh));
        minute <= 8'(bin2bcd(nn));
        sec    <= 8'(bin2bcd(ns));
      end else if (ev[BR]) begin
        cursor <= (cursor == CMAX) ? 4'd0 : cursor + 4'd1;
      end else if (ev[BL]) begin
        cursor <= (cursor == 4'd0) ? CMAX : cursor - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_set_time_editor.sv
// Bench for set_time_editor: table-driven button sequences with a scoreboard queue,
// plus hand-written latency, auto-repeat, commit, abort and reset sequences.

module tb_set_time_editor;
  localparam int DB = 4, RD = 20, RP = 5;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, en0 = 1'b0;
  logic b_mid = 1'b0, b_l = 1'b0, b_r = 1'b0, b_up = 1'b0, b_dn = 1'b0;
  logic [15:0] cur_year;
  logic [7:0]  cur_month, cur_day, cur_hour, cur_minute, cur_sec;
  logic [15:0] year, year0;
  logic [7:0]  month, day, hour, minute, sec, month0, day0, hour0, minute0, sec0;
  logic [3:0]  cursor, cursor0;
  logic        editing, commit, editing0, commit0;

  set_time_editor #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SHOW_SEC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .button_mid(b_mid), .button_l(b_l), .button_r(b_r), .button_up(b_up), .button_down(b_dn),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_sec(cur_sec),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .sec(sec),
    .cursor(cursor), .editing(editing), .commit(commit));

  set_time_editor #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SHOW_SEC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0),
    .button_mid(b_mid), .button_l(b_l), .button_r(b_r), .button_up(b_up), .button_down(b_dn),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_sec(cur_sec),
    .year(year0), .month(month0), .day(day0), .hour(hour0), .minute(minute0), .sec(sec0),
    .cursor(cursor0), .editing(editing0), .commit(commit0));

  always #5 clk = ~clk;

  localparam int MID = 0, BL = 1, BR = 2, UP = 3, DN = 4;
  typedef struct { bit s; int b; logic [59:0] e; string nm; } vec_t;
  vec_t tab[$];
  logic [59:0] sb[$];
  int pass = 0, total = 0, c1 = 0, c0 = 0;

  always @(negedge clk) begin
    if (commit)  c1 <= c1 + 1;
    if (commit0) c0 <= c0 + 1;
  end

  function automatic logic [59:0] mk(logic [15:0] y, logic [7:0] mo, logic [7:0] d,
                                     logic [7:0] h, logic [7:0] mi, logic [7:0] s, logic [3:0] c);
    return {y, mo, d, h, mi, s, c};
  endfunction

  function automatic logic [59:0] snap(bit s);
    return s ? {year0, month0, day0, hour0, minute0, sec0, cursor0}
             : {year, month, day, hour, minute, sec, cursor};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      MID:     b_mid = v;
      BL:      b_l   = v;
      BR:      b_r   = v;
      UP:      b_up  = v;
      default: b_dn  = v;
    endcase
  endtask

  task automatic press(int b);
    @(negedge clk); set_btn(b, 1'b1);
    repeat (DB + 6) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic add(bit s, int b, logic [59:0] e, string nm);
    vec_t t;
    t.s = s; t.b = b; t.e = e; t.nm = nm;
    tab.push_back(t);
  endtask

  task automatic run_tab();
    logic [59:0] e;
    for (int i = 0; i < tab.size(); i++) begin
      sb.push_back(tab[i].e);
      press(tab[i].b);
      e = sb.pop_front();
      chk(tab[i].nm, snap(tab[i].s), e);
    end
    tab.delete();
  endtask

  task automatic do_commit(bit s, logic [59:0] e, string nm);
    logic got;
    logic [59:0] exp, act;
    got = 1'b0;
    sb.push_back(e);
    @(negedge clk); b_mid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s ? commit0 : commit) begin got = 1'b1; break; end
    end
    exp = sb.pop_front();
    chk({nm, " seen"}, got, 1'b1);
    if (got) begin
      act = snap(s);
      chk({nm, " fields"}, act[59:4], exp[59:4]);
      chk({nm, " editing low"}, s ? editing0 : editing, 1'b0);
      @(negedge clk);
      chk({nm, " one cycle"}, s ? commit0 : commit, 1'b0);
    end
    b_mid = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic set_cur(logic [15:0] y, logic [7:0] mo, logic [7:0] d,
                         logic [7:0] h, logic [7:0] mi, logic [7:0] s);
    cur_year = y; cur_month = mo; cur_day = d; cur_hour = h; cur_minute = mi; cur_sec = s;
  endtask

  initial begin
    int cb;
    set_cur(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56);
    repeat (3) @(negedge clk);
    chk("reset fields", snap(0), mk(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0));
    chk("reset editing", editing, 1'b0);
    chk("reset commit", commit, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle tracks cur", snap(0), mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'd0));

    // Enter EDIT; later cur changes must not leak in.
    enable = 1'b1;
    @(posedge clk); #1;
    chk("editing rises", editing, 1'b1);
    cur_year = 16'h1999;
    repeat (3) @(negedge clk);
    chk("edit freezes copy", snap(0), mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'd0));

    for (int k = 1; k <= 5; k++)
      add(0, BR, mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'(k)), "cursor right");
    add(0, UP, mk(16'h2023, 8'h09, 8'h30, 8'h12, 8'h34, 8'h56, 4'd5), "month up day clamp");
    run_tab();
    do_commit(0, mk(16'h2023, 8'h09, 8'h30, 8'h12, 8'h34, 8'h56, 4'd0), "commit sept");

    // Leap-year day clamp on year units.
    enable = 1'b0;
    set_cur(16'h2024, 8'h02, 8'h29, 8'h10, 8'h20, 8'h30);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    b_r = 1'b1;
    repeat (DB + 3) @(posedge clk);
    #1 chk("latency before", cursor, 4'd0);
    @(posedge clk);
    #1 chk("latency at", cursor, 4'd1);
    @(negedge clk); b_r = 1'b0;
    repeat (DB + 6) @(negedge clk);
    add(0, BR, mk(16'h2024, 8'h02, 8'h29, 8'h10, 8'h20, 8'h30, 4'd2), "cursor 2");
    add(0, BR, mk(16'h2024, 8'h02, 8'h29, 8'h10, 8'h20, 8'h30, 4'd3), "cursor 3");
    add(0, DN, mk(16'h2023, 8'h02, 8'h28, 8'h10, 8'h20, 8'h30, 4'd3), "year down leap clamp");
    add(0, UP, mk(16'h2024, 8'h02, 8'h28, 8'h10, 8'h20, 8'h30, 4'd3), "year up day kept");
    run_tab();

    // Abort, then hour wrap and minute saturation.
    cb = c1;
    enable = 1'b0;
    set_cur(16'h2024, 8'h02, 8'h28, 8'h23, 8'h55, 8'h00);
    repeat (5) @(negedge clk);
    chk("abort no commit", c1, cb);
    chk("abort editing", editing, 1'b0);
    chk("abort tracks cur", snap(0), mk(16'h2024, 8'h02, 8'h28, 8'h23, 8'h55, 8'h00, 4'd0));
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 9; k++)
      add(0, BR, mk(16'h2024, 8'h02, 8'h28, 8'h23, 8'h55, 8'h00, 4'(k)), "cursor to 9");
    add(0, UP, mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h55, 8'h00, 4'd9), "hour wrap");
    add(0, BR, mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h55, 8'h00, 4'd10), "cursor 10");
    add(0, UP, mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h59, 8'h00, 4'd10), "minute saturate");
    add(0, BR, mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h59, 8'h00, 4'd11), "cursor 11");
    add(0, UP, mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h00, 8'h00, 4'd11), "minute wrap");
    run_tab();

    // Auto-repeat: one press plus three repeats.
    @(negedge clk); b_up = 1'b1;
    repeat (RD + 3 * RP) @(negedge clk);
    b_up = 1'b0;
    repeat (30) @(negedge clk);
    chk("auto repeat", snap(0), mk(16'h2024, 8'h02, 8'h28, 8'h00, 8'h04, 8'h00, 4'd11));

    // SHOW_SEC=0 instance: cursor wrap, abort, commit with sec forced to 00.
    enable = 1'b0;
    set_cur(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56);
    repeat (2) @(negedge clk);
    en0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("noshow editing", editing0, 1'b1);
    add(1, BL, mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'd11), "noshow left wrap");
    add(1, BR, mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'd0), "noshow right wrap");
    add(1, BL, mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h34, 8'h56, 4'd11), "noshow left again");
    run_tab();
    en0 = 1'b0;
    cur_minute = 8'h45;
    repeat (4) @(negedge clk);
    chk("noshow abort no commit", c0, 0);
    chk("noshow abort editing", editing0, 1'b0);
    chk("noshow tracks cur", snap(1), mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h45, 8'h56, 4'd0));
    en0 = 1'b1;
    repeat (2) @(negedge clk);
    do_commit(1, mk(16'h2023, 8'h08, 8'h31, 8'h12, 8'h45, 8'h00, 4'd0), "noshow commit");
    en0 = 1'b0;

    // Thousands digit, then reset in the middle of an edit.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    add(0, UP, mk(16'h3023, 8'h08, 8'h31, 8'h12, 8'h45, 8'h56, 4'd0), "year thousands up");
    run_tab();
    cb = c1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset mid edit fields", snap(0), mk(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0));
    chk("reset mid edit editing", editing, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset mid edit no commit", c1, cb);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/set_time_editor.md
# set_time_editor

Parametrised date/time editor for the clock's set mode. It replaces the fixed cursor-and-button setter with debounced buttons, auto-repeat on up/down, per-field range arithmetic with leap-year-aware day clamping, an optional seconds field, and an explicit commit/abort handshake. It sits between the raw push-buttons and the timekeeping counter. The display string selector reads `cursor` and the BCD outputs.

## Interface

- `DEBOUNCE`, default 16: cycles a synchronised button level must stay stable before it is accepted (≥1).
- `REPEAT_DELAY`, default 50_000_000: held-cycles before up/down auto-repeat starts.
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat events.
- `SHOW_SEC`, default 1: 1 = seconds editable; 0 = seconds field skipped and committed as 00.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: high while the clock is in set mode.
- `button_mid`, `button_l`, `button_r`, `button_up`, `button_down` in 1 each: raw asynchronous button levels, active-high.
- `cur_year` in 16: current year, 4 BCD digits.
- `cur_month`, `cur_day`, `cur_hour`, `cur_minute`, `cur_sec` in 8 each: current time, 2 BCD digits each.
- `year` out 16: edited year, BCD.
- `month`, `day`, `hour`, `minute`, `sec` out 8 each: edited fields, BCD.
- `cursor` out 4: selected digit index.
- `editing` out 1: high in EDIT.
- `commit` out 1: one-cycle pulse; outputs are valid to load on this cycle.

## Operation

- **Button path.** Each button goes through a 2-flop synchroniser, then a stability counter. The debounced level toggles when the synchronised level has differed from it for `DEBOUNCE` consecutive cycles. A press event is the debounced rising edge.
- **Auto-repeat (up/down only).** While the debounced level stays high, an extra event fires after `REPEAT_DELAY` cycles. Further events follow every `REPEAT_PERIOD` cycles. l/r/mid never repeat.
- **States:**
  - IDLE: output registers copy `cur_*` every cycle; `cursor`=0.
  - IDLE→EDIT on the `enable` rising edge. The copy freezes at the value from the last IDLE cycle.
  - EDIT→IDLE with `commit`=1 on a mid press.
  - EDIT→IDLE with no commit when `enable` falls (abort).
- **Cursor digits:** 0–3 year thousands..units, 4–5 month, 6–7 day, 8–9 hour, 10–11 minute, 12–13 sec.
  - Range is 0..13 (SHOW_SEC=1) or 0..11 (SHOW_SEC=0).
  - r = +1, l = −1, both wrapping at the ends of the range.
- **Field ranges:** year 0000–9999; month 01–12; day 01–DIM; hour 00–23; minute and sec 00–59.
- **Digit arithmetic:**
  - Units digit: up/down changes the field by ±1 and wraps max↔min.
  - Tens, hundreds and thousands digits: up/down changes the field by ±10/100/1000 and saturates at max/min.
- **DIM (days in month):**
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Feb: 29 if leap, else 28. Leap means (year mod 4 = 0 and year mod 100 ≠ 0) or year mod 400 = 0.
- **Day clamp.** After any month or year change, day is set to min(day, DIM of the new month/year) in the same update.
- **Priority.** At most one action per cycle, in this order: abort > mid > up/down > r/l. Simultaneous lower-priority events are dropped, not queued. up and down together cancel each other.
- **SHOW_SEC=0:** on `commit`, `sec` = 00.

## Timing

- **Reset values:**
  - `year`=2000, `month`=01, `day`=01, `hour`/`minute`/`sec`=00.
  - `cursor`=0, `editing`=0, `commit`=0.
  - State IDLE; debounced levels and counters at 0.
- **Button latency.** A raw press stable from cycle t gives a debounced edge at t+2+DEBOUNCE. The field, cursor or commit register updates at t+3+DEBOUNCE.
- **enable.** `editing` rises 1 cycle after `enable` is first sampled high. An abort takes effect 1 cycle after `enable` is sampled low; `editing` returns to 0 and IDLE tracking resumes.
- **commit.** `commit` is high for exactly one cycle, with `editing`=0 from that same cycle. Outputs are held stable on the commit cycle.
- **Reset mid-operation.** Reset during EDIT discards all edits immediately, with no commit.
- **Buttons held across transitions.** A button held across an EDIT entry generates no event until it is released and pressed again.

## Test plan

1. Reset, load cur=2023-08-31 12:34:56, raise `enable`, DEBOUNCE=4 → `editing`=1 at the next cycle; outputs hold 2023-08-31 12:34:56.
2. With the cursor on digit 5 (via 5 r presses), press up once → month 09 and day clamps to 30. Then press mid → one `commit` pulse carrying 2023-09-30.
3. Start from 2024-02-29, cursor on digit 3, press down → year 2023, day 28. Press up → year 2024, day stays 28.
4. Set hour 23, cursor on digit 9, press up → 00. Set minute 55, cursor on digit 10, press up → 59 (saturate).
5. Hold up for REPEAT_DELAY + 3×REPEAT_PERIOD cycles (DELAY=20, PERIOD=5) on minute units starting at 00 → minute 04.
6. SHOW_SEC=0, cursor at 11, press r → cursor 0. Press l → cursor 11. Drop `enable` → no commit, outputs track `cur_*` again.
